// File: rtl/config_loader.sv
// Serial configuration loader: clears a tile configuration shift chain, then
// streams host bitstream words into it LSB first, one bit per clock.
module config_loader #(
  parameter int CHAIN_LENGTH = 146,
  parameter int WORD_WIDTH   = 8,
  parameter int TIMEOUT      = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_out,
  output logic                  config_enable,
  output logic                  config_nreset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int NUM_WORDS = (CHAIN_LENGTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int BL_W      = $clog2(WORD_WIDTH + 1);
  localparam int WC_W      = $clog2(NUM_WORDS + 1);
  localparam int SC_W      = $clog2(CHAIN_LENGTH + 1);
  localparam int IC_W      = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_FINISH
  } state_t;

  state_t                state_q,     state_d;
  logic                  clr_cnt_q,   clr_cnt_d;
  logic                  failed_q,    failed_d;
  logic [WORD_WIDTH-1:0] shreg_q,     shreg_d;
  logic [BL_W-1:0]       bits_left_q, bits_left_d;
  logic [WC_W-1:0]       words_q,     words_d;
  logic [SC_W-1:0]       shift_cnt_q, shift_cnt_d;
  logic [IC_W-1:0]       idle_cnt_q,  idle_cnt_d;
  logic                  error_q,     error_d;

  logic pending;
  logic ready_int;
  logic accept;
  logic shift_en;
  logic timeout_hit;

  // Ready on the last bit of a word lets the next word follow with no gap.
  always_comb begin
    pending     = (bits_left_q != '0);
    ready_int   = (state_q == S_LOAD) && (bits_left_q <= BL_W'(1)) &&
                  (words_q < WC_W'(NUM_WORDS)) && !abort;
    accept      = ready_int && word_valid;
    shift_en    = (state_q == S_LOAD) && pending &&
                  (shift_cnt_q < SC_W'(CHAIN_LENGTH));
    timeout_hit = (state_q == S_LOAD) && !pending && !accept &&
                  (idle_cnt_q == IC_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      clr_cnt_q   <= 1'b0;
      failed_q    <= 1'b0;
      shreg_q     <= '0;
      bits_left_q <= '0;
      words_q     <= '0;
      shift_cnt_q <= '0;
      idle_cnt_q  <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      failed_q    <= failed_d;
      shreg_q     <= shreg_d;
      bits_left_q <= bits_left_d;
      words_q     <= words_d;
      shift_cnt_q <= shift_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    failed_d    = failed_q;
    shreg_d     = shreg_q;
    bits_left_d = bits_left_q;
    words_d     = words_q;
    shift_cnt_d = shift_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    error_d     = error_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_CLEAR;
          clr_cnt_d   = 1'b0;
          failed_d    = 1'b0;
          error_d     = 1'b0;
          shreg_d     = '0;
          bits_left_d = '0;
          words_d     = '0;
          shift_cnt_d = '0;
          idle_cnt_d  = '0;
        end
      end
      S_CLEAR: begin
        if (abort) begin
          // Restart the clear so the chain is fully wiped before returning.
          error_d   = 1'b1;
          failed_d  = 1'b1;
          clr_cnt_d = 1'b0;
        end else if (clr_cnt_q) begin
          clr_cnt_d = 1'b0;
          state_d   = failed_q ? S_IDLE : S_LOAD;
        end else begin
          clr_cnt_d = 1'b1;
        end
      end
      S_LOAD: begin
        if (abort || timeout_hit) begin
          state_d     = S_CLEAR;
          clr_cnt_d   = 1'b0;
          failed_d    = 1'b1;
          error_d     = 1'b1;
          shreg_d     = '0;
          bits_left_d = '0;
          words_d     = '0;
          shift_cnt_d = '0;
          idle_cnt_d  = '0;
        end else begin
          if (pending) begin
            shreg_d     = shreg_q >> 1;
            bits_left_d = bits_left_q - BL_W'(1);
          end
          if (shift_en) begin
            shift_cnt_d = shift_cnt_q + SC_W'(1);
          end
          if (accept) begin
            shreg_d     = word_in;
            bits_left_d = BL_W'(WORD_WIDTH);
            words_d     = words_q + WC_W'(1);
            idle_cnt_d  = '0;
          end else if (!pending) begin
            idle_cnt_d = idle_cnt_q + IC_W'(1);
          end
          // Leftover bits of the final word are dropped by leaving LOAD here.
          if (shift_cnt_d == SC_W'(CHAIN_LENGTH)) begin
            state_d = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    word_ready    = ready_int;
    config_enable = shift_en;
    config_out    = shift_en & shreg_q[0];
    config_nreset = (state_q != S_CLEAR);
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_FINISH);
    error         = error_q;
  end

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: models the target chain and checks loads,
// stalls, truncation, timeout, abort, busy start and reset behaviour.
module tb_config_loader;

  localparam int CL = 146;
  localparam int WW = 8;
  localparam int TO = 16;
  localparam int NW = 19;

  typedef logic [CL-1:0] vec_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [WW-1:0] word_in = '0;
  logic          word_valid = 1'b0;
  logic          word_ready, config_out, config_enable, config_nreset;
  logic          busy, done, error;

  int n_checks = 0;
  int n_errors = 0;

  logic [WW-1:0] words [NW];

  always #5 clock = ~clock;

  config_loader #(
    .CHAIN_LENGTH(CL),
    .WORD_WIDTH  (WW),
    .TIMEOUT     (TO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .word_in      (word_in),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .config_out   (config_out),
    .config_enable(config_enable),
    .config_nreset(config_nreset),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  // Chain model: first bit shifted in ends up at chain[0] after CL shifts.
  vec_t chain = '0;
  int   cyc = 0, en_total = 0, nrst_low = 0, done_total = 0, both_high = 0;
  int   run_cur = 0, last_run = 0, last_en_cyc = 0, err_rise_cyc = 0;
  logic err_prev = 1'b0;

  always @(negedge clock) begin
    cyc++;
    if (config_nreset === 1'b0) begin
      chain = '0;
      nrst_low++;
    end else if (config_enable === 1'b1) begin
      chain = {config_out, chain[CL-1:1]};
    end
    if (config_enable === 1'b1) begin
      en_total++;
      run_cur++;
      last_en_cyc = cyc;
    end else begin
      if (run_cur > 0) last_run = run_cur;
      run_cur = 0;
    end
    if (done === 1'b1) done_total++;
    if (done === 1'b1 && error === 1'b1) both_high++;
    if (error === 1'b1 && err_prev !== 1'b1) err_rise_cyc = cyc;
    err_prev = error;
  end

  task automatic check(input string tag, input vec_t got, input vec_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  function automatic vec_t expect_chain();
    vec_t e;
    for (int i = 0; i < CL; i++) e[i] = words[i / WW][i % WW];
    return e;
  endfunction

  // gap = cycles with the chain idle between draining one word and the next.
  task automatic send_word(input logic [WW-1:0] w, input int gap);
    int t;
    t = 0;
    word_in    = w;
    word_valid = (gap == 0);
    while (!word_ready && t < 64) begin
      tick();
      t++;
    end
    if (t >= 64) check("ready_wait", vec_t'(word_ready), vec_t'(1));
    repeat (gap) tick();
    word_valid = 1'b1;
    tick();
  endtask

  task automatic run_load(input int gap, input int busy_start_at, input string tag);
    int en0, nr0, dn0, t;
    en0 = en_total;
    nr0 = nrst_low;
    dn0 = done_total;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int w = 0; w < NW; w++) begin
      if (w == busy_start_at) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      send_word(words[w], (w == 0) ? 0 : gap);
    end
    word_valid = 1'b0;
    t = 0;
    while (busy && t < 400) begin
      tick();
      t++;
    end
    $display("load %s: %0d enabled cycles, done pulses %0d", tag, en_total - en0, done_total - dn0);
    check({tag, "_idle"}, vec_t'(busy), vec_t'(0));
    check({tag, "_chain"}, chain, expect_chain());
    check({tag, "_en_cycles"}, vec_t'(en_total - en0), vec_t'(CL));
    check({tag, "_nreset_low"}, vec_t'(nrst_low - nr0), vec_t'(2));
    check({tag, "_done"}, vec_t'(done_total - dn0), vec_t'(1));
    check({tag, "_err"}, vec_t'(error), vec_t'(0));
  endtask

  initial begin
    int t, en0, nr0, dn0;

    // Reset wins over simultaneous start and abort.
    start = 1'b1;
    abort = 1'b1;
    repeat (3) tick();
    check("reset_outputs", vec_t'({word_ready, config_out, config_enable, config_nreset, busy, done, error}),
          vec_t'(7'b0001000));
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    tick();
    check("reset_idle", vec_t'(busy), vec_t'(0));

    // Continuous stream.
    for (int i = 0; i < NW; i++) words[i] = WW'(i * 37 + 5);
    run_load(0, -1, "cont");
    check("cont_run", vec_t'(last_run), vec_t'(CL));

    // Stalled stream: last run is the 2 kept bits of the final word.
    for (int i = 0; i < NW; i++) words[i] = WW'((i * 90) ^ 51);
    run_load(3, -1, "stall");
    check("stall_last_run", vec_t'(last_run), vec_t'(2));

    // Truncated last word of all ones.
    for (int i = 0; i < NW; i++) words[i] = WW'(~(i * 11));
    words[NW-1] = 8'hFF;
    run_load(0, -1, "trunc");
    check("trunc_top_bits", vec_t'(chain[CL-1:CL-2]), vec_t'(2'b11));

    // Timeout after 5 words.
    dn0 = done_total;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int w = 0; w < 5; w++) send_word(words[w], 0);
    word_valid = 1'b0;
    t = 0;
    while (!error && t < 200) begin
      tick();
      t++;
    end
    nr0 = nrst_low;
    $display("timeout: error after %0d cycles", err_rise_cyc - last_en_cyc);
    check("timeout_error", vec_t'(error), vec_t'(1));
    // error rises TO edges after the edge that shifted the last bit.
    check("timeout_latency", vec_t'(err_rise_cyc - last_en_cyc), vec_t'(TO + 1));
    t = 0;
    while (busy && t < 20) begin
      tick();
      t++;
    end
    check("timeout_nreset_low", vec_t'(nrst_low - nr0 + 1), vec_t'(2));
    check("timeout_done", vec_t'(done_total - dn0), vec_t'(0));
    check("timeout_chain_clear", chain, vec_t'(0));
    repeat (3) tick();
    check("timeout_idle", vec_t'({busy, word_ready}), vec_t'(0));
    check("error_sticky", vec_t'(error), vec_t'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_in_idle", vec_t'({busy, error}), vec_t'(2'b01));

    // Start and abort together in IDLE start a load; abort during word 10.
    dn0 = done_total;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", vec_t'({busy, error}), vec_t'(2'b10));
    for (int w = 0; w < 10; w++) send_word(words[w], 0);
    word_valid = 1'b0;
    repeat (3) tick();
    nr0 = nrst_low;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_error", vec_t'(error), vec_t'(1));
    t = 0;
    while (busy && t < 20) begin
      tick();
      t++;
    end
    check("abort_nreset_low", vec_t'(nrst_low - nr0), vec_t'(2));
    check("abort_done", vec_t'(done_total - dn0), vec_t'(0));
    check("abort_chain_clear", chain, vec_t'(0));

    // A start while loading has no effect.
    for (int i = 0; i < NW; i++) words[i] = WW'(i * 73 + 200);
    run_load(0, 6, "busy_start");

    // Reset mid-load at bit 70.
    en0 = en_total;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int w = 0; w < 9; w++) send_word(words[w], 0);
    word_valid = 1'b0;
    t = 0;
    while ((en_total - en0) < 70 && t < 200) begin
      tick();
      t++;
    end
    reset = 1'b1;
    tick();
    check("midload_reset_outputs",
          vec_t'({word_ready, config_out, config_enable, config_nreset, busy, done, error}),
          vec_t'(7'b0001000));
    reset = 1'b0;
    tick();
    for (int i = 0; i < NW; i++) words[i] = WW'(255 - i * 13);
    run_load(0, -1, "after_reset");

    check("done_error_overlap", vec_t'(both_high), vec_t'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL have parameter CHAIN_LENGTH, default 146, giving the number of bits in the target tile configuration shift chain.
REQ-002 SHALL have parameter WORD_WIDTH, default 8, giving the width of the host bitstream word.
REQ-003 SHALL have parameter TIMEOUT, default 1024, giving the maximum idle cycles allowed waiting for a word during LOAD.
REQ-004 SHALL derive NUM_WORDS = ceil(CHAIN_LENGTH/WORD_WIDTH), which is 19 at defaults.
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-007 SHALL have port start, input, 1 bit: a one-cycle request to begin a load.
REQ-008 SHALL have port abort, input, 1 bit: cancels the load in progress.
REQ-009 SHALL have port word_in, input, WORD_WIDTH bits: the bitstream word, shifted out LSB first.
REQ-010 SHALL have port word_valid, input, 1 bit: word_in is valid.
REQ-011 SHALL have port word_ready, output, 1 bit: the loader accepts word_in this cycle.
REQ-012 SHALL have port config_out, output, 1 bit: serial data to the chain config_in.
REQ-013 SHALL have port config_enable, output, 1 bit: the chain shifts one bit on this clock edge.
REQ-014 SHALL have port config_nreset, output, 1 bit: active-low clear of the chain.
REQ-015 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse when a load completes successfully.
REQ-017 SHALL have port error, output, 1 bit: sticky flag set on timeout or abort.

Function
REQ-018 SHALL implement the states IDLE, CLEAR, LOAD and FINISH.
REQ-019 In IDLE, start=1 SHALL move the FSM to CLEAR, clear error, and zero all counters.
REQ-020 CLEAR SHALL drive config_nreset=0 for exactly 2 cycles and then go to LOAD.
REQ-021 In LOAD, word_ready SHALL equal (bits left in the current word <= 1) AND (words accepted < NUM_WORDS) AND NOT abort.
REQ-022 A word SHALL be accepted when word_valid=1 and word_ready=1; word_in SHALL NOT be sampled at any other time.
REQ-023 Shifting SHALL start the cycle after acceptance, with one bit per cycle, config_enable=1, and config_out equal to the current LSB.
REQ-024 When a word is accepted during the last-bit cycle of the previous word, shifting SHALL continue with no gap, so a continuous stream gives config_enable high for exactly CHAIN_LENGTH consecutive cycles.
REQ-025 A bit counter 0..CHAIN_LENGTH-1 SHALL count the enabled shifts.
REQ-026 Bits of the last word at positions CHAIN_LENGTH and above (6 bits at defaults) SHALL be discarded, with config_enable=0 for them.
REQ-027 When the shift counter reaches CHAIN_LENGTH, the FSM SHALL go to FINISH.
REQ-028 FINISH SHALL last 1 cycle, pulse done=1, and return to IDLE.
REQ-029 When no bits are pending in LOAD, config_enable SHALL be 0 and config_out SHALL be 0.
REQ-030 The idle counter SHALL increment each LOAD cycle with no bits pending and no acceptance, and SHALL clear on acceptance.
REQ-031 When the idle counter reaches TIMEOUT, the FSM SHALL set error=1 and go to CLEAR, then to IDLE instead of LOAD, so no partial configuration is left in the chain.
REQ-032 abort=1 in CLEAR or LOAD SHALL have the same effect as a timeout; abort in IDLE SHALL be ignored.
REQ-033 start while busy=1 SHALL be ignored.
REQ-034 When start and abort are asserted together in IDLE, the load SHALL start.
REQ-035 error SHALL remain set until the next accepted start or reset.
REQ-036 done and error SHALL never be high in the same cycle.
REQ-037 config_nreset SHALL be 1 outside CLEAR.

Reset
REQ-038 reset=1 SHALL force state IDLE regardless of the current state, including mid-LOAD.
REQ-039 Under reset, all counters SHALL be 0 and the shift register SHALL be 0.
REQ-040 Under reset, the outputs SHALL be word_ready=0, config_out=0, config_enable=0, config_nreset=1, busy=0, done=0 and error=0.
REQ-041 reset SHALL take priority over start and abort.
REQ-042 A chain left partially loaded by reset SHALL be cleared only by the next CLEAR state.

Verification
REQ-043 Scenario, continuous load: start, then 19 words with word_valid held at 1 -> config_nreset low for 2 cycles, config_enable high for 146 consecutive cycles with config_out matching the LSB-first concatenated stream, and done high for 1 cycle.
REQ-044 Scenario, stalled input: 3-cycle word_valid gaps between words -> config_enable low during each gap, no bits lost or duplicated, and total enabled cycles equal to 146.
REQ-045 Scenario, truncated last word: last word 0xFF -> only bits 0-1 are shifted, and the chain contents equal the reference model.
REQ-046 Scenario, timeout: TIMEOUT=16 and input stops after 5 words -> error=1 16 cycles after the last shift, config_nreset low for 2 cycles, then IDLE, and done is never asserted.
REQ-047 Scenario, abort and busy start: abort in word 10, and a separate start issued while in LOAD -> the abort gives the timeout behaviour, and the busy start has no effect on the state or counters.
REQ-048 Scenario, reset mid-load: reset at bit 70 -> the next cycle shows every output at its reset value, and a fresh start then loads correctly.
